seq_extract: RTL and testbench

Receive-side counterpart of the downlink calibration-sequence inserter. It watches the uplink sample stream during RX calibration windows and captures the calibration samples for each enabled antenna into an external capture RAM. In each window it counts samples and mismatches against the expected amplitude sequence, then reports a per-window result. It sits in the 245.76 MHz uplink datapath, between the uplink data mux and the calibration-result RAM.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_extract_if.sv | 35 +++
 rtl/seq_align_dly.sv | 26 ++
 rtl/seq_extract.sv | 180 ++++++++++++++++++
 tb/tb_seq_extract.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and widths for the calibration-sequence extractor.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      REPORT  = 2'd2
   } state_t;

   localparam int ANT_NUM_EN = 4;   // antennas that can ever be captured
   localparam int SEQ_IDX_W  = 7;
   localparam int CAP_ADDR_W = 10;  // {ant[2:0], seq[6:0]}
   localparam int ANT_W      = 3;
   localparam int SMP_W      = 32;  // {I[15:0], Q[15:0]}
   localparam int ERR_W      = 8;

endpackage

// File: rtl/seq_extract_if.sv
// Signal bundle between the uplink datapath, the extractor and the capture RAM.
interface seq_extract_if;
   import seq_pkg::*;

   logic [SMP_W-1:0]      ul_rdata;
   logic                  rx_seq_valid;
   logic [ANT_W-1:0]      rx_ant_cnt;
   logic [SEQ_IDX_W-1:0]  i_seq_cnt;
   logic [ANT_NUM_EN-1:0] reg_cal_ant_en;
   logic                  i_seq_extract_en;
   logic [SMP_W-1:0]      amp_seq0, amp_seq1, amp_seq2, amp_seq3;
   logic [SMP_W-1:0]      amp_seq4, amp_seq5, amp_seq6, amp_seq7;

   logic                  o_cap_wr;
   logic [CAP_ADDR_W-1:0] o_cap_addr;
   logic [SMP_W-1:0]      o_cap_data;
   logic                  o_done;
   logic                  o_abort;
   logic [ANT_W-1:0]      o_ant_idx;
   logic [SEQ_IDX_W-1:0]  o_smp_cnt;
   logic [ERR_W-1:0]      o_err_cnt;

   modport master (
      output ul_rdata, rx_seq_valid, rx_ant_cnt, i_seq_cnt, reg_cal_ant_en, i_seq_extract_en,
      output amp_seq0, amp_seq1, amp_seq2, amp_seq3, amp_seq4, amp_seq5, amp_seq6, amp_seq7,
      input  o_cap_wr, o_cap_addr, o_cap_data, o_done, o_abort, o_ant_idx, o_smp_cnt, o_err_cnt
   );

   modport slave (
      input  ul_rdata, rx_seq_valid, rx_ant_cnt, i_seq_cnt, reg_cal_ant_en, i_seq_extract_en,
      input  amp_seq0, amp_seq1, amp_seq2, amp_seq3, amp_seq4, amp_seq5, amp_seq6, amp_seq7,
      output o_cap_wr, o_cap_addr, o_cap_data, o_done, o_abort, o_ant_idx, o_smp_cnt, o_err_cnt
   );

endinterface

// File: rtl/seq_align_dly.sv
// Fixed-depth shift register that lines the window controls up with ul_rdata.
module seq_align_dly #(
   parameter int ALIGN_DLY = 11,
   parameter int WIDTH     = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr_p [ALIGN_DLY];

   // shift controls one stage per cycle; reset empties the whole line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ALIGN_DLY; i++) sr_p[i] <= '0;
      end else begin
         sr_p[0] <= din;
         for (int i = 1; i < ALIGN_DLY; i++) sr_p[i] <= sr_p[i-1];
      end
   end

   assign dout = sr_p[ALIGN_DLY-1];

endmodule

// File: rtl/seq_extract.sv
// Uplink calibration-sequence extractor: captures enabled-antenna windows into
// the capture RAM and reports sample/mismatch counts per window.
// Optional macro SEQ_EXTRACT_CMP_EN enables the amp_seq comparator; without it
// o_err_cnt stays 0 and amp_seq* are ignored.
// Outputs are registered from the decision taken on the aligned controls, so
// o_cap_wr/o_done/o_abort are visible in the cycle the FSM sits in the
// corresponding state.
module seq_extract
   import seq_pkg::*;
#(
   parameter int ALIGN_DLY = 11,
   parameter int MAX_LEN   = 127
) (
   input  logic         clk_245p76,
   input  logic         asy_rst,
   seq_extract_if.slave bus
);

   logic                 valid_d;
   logic [ANT_W-1:0]     ant_d;
   logic [SEQ_IDX_W-1:0] seq_d;
   logic                 valid_d_p1;
   state_t               state_q, state_d;
   logic [ANT_W-1:0]     cur_ant_q;
   logic [SEQ_IDX_W-1:0] smp_cnt_q;
   logic [ERR_W-1:0]     err_cnt_q;
   logic                 ant_en, rise, wr, fresh, report, abort, mism;

   function automatic logic [SEQ_IDX_W-1:0] sat_smp_inc(input logic [SEQ_IDX_W-1:0] c);
      if (c >= SEQ_IDX_W'(MAX_LEN)) return SEQ_IDX_W'(MAX_LEN);
      return c + 1'b1;
   endfunction

   function automatic logic [ERR_W-1:0] sat_err_inc(input logic [ERR_W-1:0] c, input logic inc);
      if (!inc || (c == '1)) return c;
      return c + 1'b1;
   endfunction

   seq_align_dly #(
      .ALIGN_DLY (ALIGN_DLY),
      .WIDTH     (1 + ANT_W + SEQ_IDX_W)
   ) u_align (
      .clk  (clk_245p76),
      .rst  (asy_rst),
      .din  ({bus.rx_seq_valid, bus.rx_ant_cnt, bus.i_seq_cnt}),
      .dout ({valid_d, ant_d, seq_d})
   );

   assign ant_en = bus.i_seq_extract_en & (ant_d < ANT_W'(ANT_NUM_EN))
                 & bus.reg_cal_ant_en[ant_d[1:0]];
   assign rise   = valid_d & ~valid_d_p1;

`ifdef SEQ_EXTRACT_CMP_EN
   logic [SMP_W-1:0] exp_smp;

   // pick the expected sample; it is compared on the same edge the sample is captured
   always_comb begin
      exp_smp = bus.amp_seq7;
      case (seq_d[2:0])
         3'd0: exp_smp = bus.amp_seq0;
         3'd1: exp_smp = bus.amp_seq1;
         3'd2: exp_smp = bus.amp_seq2;
         3'd3: exp_smp = bus.amp_seq3;
         3'd4: exp_smp = bus.amp_seq4;
         3'd5: exp_smp = bus.amp_seq5;
         3'd6: exp_smp = bus.amp_seq6;
         default: exp_smp = bus.amp_seq7;
      endcase
   end

   assign mism = (bus.ul_rdata != exp_smp);
`else
   logic unused_amp;
   assign unused_amp = ^{bus.amp_seq0, bus.amp_seq1, bus.amp_seq2, bus.amp_seq3,
                         bus.amp_seq4, bus.amp_seq5, bus.amp_seq6, bus.amp_seq7};
   assign mism = 1'b0;
`endif

   // previous aligned valid, for rising-edge detection
   always_ff @(posedge clk_245p76 or posedge asy_rst) begin
      if (asy_rst) valid_d_p1 <= 1'b0;
      else         valid_d_p1 <= valid_d;
   end

   // FSM state register
   always_ff @(posedge clk_245p76 or posedge asy_rst) begin
      if (asy_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // next state plus per-cycle write/report/abort decisions
   always_comb begin
      state_d = state_q;
      wr      = 1'b0;
      fresh   = 1'b0;
      report  = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise && ant_en) begin
               state_d = CAPTURE;
               wr      = 1'b1;
               fresh   = 1'b1;
            end
         end
         CAPTURE: begin
            if (!bus.i_seq_extract_en) begin
               state_d = IDLE;
               abort   = 1'b1;
            end else if (!valid_d || (ant_d != cur_ant_q)) begin
               state_d = REPORT;
               report  = 1'b1;
            end else begin
               wr = 1'b1;
            end
         end
         REPORT: begin
            if (valid_d && ant_en) begin
               state_d = CAPTURE;
               wr      = 1'b1;
               fresh   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // per-window antenna, sample and mismatch counters
   always_ff @(posedge clk_245p76 or posedge asy_rst) begin
      if (asy_rst) begin
         cur_ant_q <= '0;
         smp_cnt_q <= '0;
         err_cnt_q <= '0;
      end else if (fresh) begin
         cur_ant_q <= ant_d;
         smp_cnt_q <= SEQ_IDX_W'(1);
         err_cnt_q <= ERR_W'(mism);
      end else if (wr) begin
         smp_cnt_q <= sat_smp_inc(smp_cnt_q);
         err_cnt_q <= sat_err_inc(err_cnt_q, mism);
      end
   end

   // capture RAM write port
   always_ff @(posedge clk_245p76 or posedge asy_rst) begin
      if (asy_rst) begin
         bus.o_cap_wr   <= 1'b0;
         bus.o_cap_addr <= '0;
         bus.o_cap_data <= '0;
      end else begin
         bus.o_cap_wr <= wr;
         if (wr) begin
            bus.o_cap_addr <= {ant_d, seq_d};
            bus.o_cap_data <= bus.ul_rdata;
         end
      end
   end

   // window result pulses and held report values
   always_ff @(posedge clk_245p76 or posedge asy_rst) begin
      if (asy_rst) begin
         bus.o_done    <= 1'b0;
         bus.o_abort   <= 1'b0;
         bus.o_ant_idx <= '0;
         bus.o_smp_cnt <= '0;
         bus.o_err_cnt <= '0;
      end else begin
         bus.o_done  <= report;
         bus.o_abort <= abort;
         if (report) begin
            bus.o_ant_idx <= cur_ant_q;
            bus.o_smp_cnt <= smp_cnt_q;
            bus.o_err_cnt <= err_cnt_q;
         end
      end
   end

endmodule

// File: tb/tb_seq_extract.sv
// Bench for seq_extract: directed windows plus a randomized tail, all checked
// cycle by cycle against a window-level reference model.
module tb_seq_extract;

   localparam int A = 11;
   localparam int N = 1200;

   logic clk = 1'b0;
   logic asy_rst;

   seq_extract_if bus();

   seq_extract #(.ALIGN_DLY(A), .MAX_LEN(127)) dut (
      .clk_245p76 (clk),
      .asy_rst    (asy_rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // stimulus, indexed by the clock edge that samples it
   logic        s_v    [N];
   logic [2:0]  s_ant  [N];
   logic [6:0]  s_seq  [N];
   logic [31:0] s_data [N];
   logic        s_en   [N];
   logic [3:0]  s_mask [N];
   logic        s_rst  [N];
   logic [31:0] amp    [8];

   // expected outputs after each edge
   logic        e_wr   [N];
   logic        e_done [N];
   logic        e_abort[N];
   logic [9:0]  e_addr [N];
   logic [31:0] e_data [N];
   logic [2:0]  e_ant  [N];
   logic [6:0]  e_smp  [N];
   logic [7:0]  e_err  [N];

   int cp_t[$], cp_ant[$], cp_smp[$], cp_err[$];

   int n_chk, n_pass;

   task automatic check_val(input string tag, input int t, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, t, obs, exp);
   endtask

   task automatic put_sample(input int t, input logic [2:0] ant, input logic [6:0] seq,
                             input logic bad);
      s_v[t]      = 1'b1;
      s_ant[t]    = ant;
      s_seq[t]    = seq;
      s_data[t+A] = bad ? ~amp[seq[2:0]] : amp[seq[2:0]];
   endtask

   task automatic add_window(input int t0, input int len, input logic [2:0] ant,
                             input logic [7:0] bad_idx, input logic all_bad);
      for (int i = 0; i < len; i++)
         put_sample(t0 + i, ant, 7'(i), all_bad || (i < 8 && bad_idx[i % 8]));
   endtask

   task automatic set_mask(input int from, input logic [3:0] m);
      for (int t = from; t < N; t++) s_mask[t] = m;
   endtask

   task automatic add_cp(input int t, input int ant, input int smp, input int err);
      cp_t.push_back(t); cp_ant.push_back(ant); cp_smp.push_back(smp); cp_err.push_back(err);
   endtask

   // window-level model: a sample seen A edges after its controls either opens,
   // extends, closes or aborts a window
   task automatic run_model();
      logic       open_w, closing, prev_v, v, en_ant, bad, start;
      logic [2:0] w_ant, ant, r_ant;
      logic [6:0] seq;
      int         n, e, r_smp, r_err, last_rst, s;
      open_w = 0; closing = 0; prev_v = 0; w_ant = 0; r_ant = 0;
      n = 0; e = 0; r_smp = 0; r_err = 0; last_rst = -1;
      for (int t = 0; t < N; t++) begin
         e_wr[t] = 0; e_done[t] = 0; e_abort[t] = 0; e_addr[t] = 0; e_data[t] = 0;
         if (s_rst[t]) begin
            open_w = 0; closing = 0; prev_v = 0; n = 0; e = 0;
            r_ant = 0; r_smp = 0; r_err = 0; last_rst = t;
         end else begin
            s = t - A;
            v = (s >= 0 && s > last_rst) ? s_v[s] : 1'b0;
            ant = v ? s_ant[s] : 3'd0;
            seq = v ? s_seq[s] : 7'd0;
            en_ant = s_en[t] && (ant < 3'd4) && s_mask[t][ant[1:0]];
`ifdef SEQ_EXTRACT_CMP_EN
            bad = (s_data[t] != amp[seq[2:0]]);
`else
            bad = 1'b0;
`endif
            start = 0;
            if (closing) begin
               closing = 0;
               start = v && en_ant;
            end else if (!open_w) begin
               start = v && !prev_v && en_ant;
            end else if (!s_en[t]) begin
               e_abort[t] = 1; open_w = 0;
            end else if (!v || ant != w_ant) begin
               e_done[t] = 1; open_w = 0; closing = 1;
               r_ant = w_ant; r_smp = n; r_err = e;
            end else begin
               e_wr[t] = 1;
               n = (n < 127) ? n + 1 : 127;
               e = (e < 255) ? e + int'(bad) : 255;
            end
            if (start) begin
               open_w = 1; w_ant = ant; n = 1; e = int'(bad); e_wr[t] = 1;
            end
            if (e_wr[t]) begin
               e_addr[t] = {ant, seq};
               e_data[t] = s_data[t];
            end
            prev_v = v;
         end
         e_ant[t] = r_ant;
         e_smp[t] = 7'(r_smp);
         e_err[t] = 8'(r_err);
      end
   endtask

   task automatic check_reset_zero(input int t);
      check_val("rst_cap_wr",  t, 32'(bus.o_cap_wr),   32'd0);
      check_val("rst_addr",    t, 32'(bus.o_cap_addr), 32'd0);
      check_val("rst_data",    t, bus.o_cap_data,      32'd0);
      check_val("rst_done",    t, 32'(bus.o_done),     32'd0);
      check_val("rst_abort",   t, 32'(bus.o_abort),    32'd0);
      check_val("rst_ant_idx", t, 32'(bus.o_ant_idx),  32'd0);
      check_val("rst_smp_cnt", t, 32'(bus.o_smp_cnt),  32'd0);
      check_val("rst_err_cnt", t, 32'(bus.o_err_cnt),  32'd0);
   endtask

   initial begin
      int t;
      int len;
      int err2, err200;
      logic [2:0] ant;
      n_chk = 0;
      n_pass = 0;
`ifdef SEQ_EXTRACT_CMP_EN
      err2 = 2; err200 = 200;
`else
      err2 = 0; err200 = 0;
`endif
      for (int i = 0; i < 8; i++) amp[i] = $urandom;
      for (int i = 0; i < N; i++) begin
         s_v[i] = 0; s_ant[i] = 3'($urandom); s_seq[i] = 7'($urandom);
         s_data[i] = $urandom; s_en[i] = 1; s_mask[i] = 4'b0001; s_rst[i] = (i < 3);
      end

      // basic window on antenna 0, then one with two corrupted samples
      add_window(20, 8, 3'd0, 8'h00, 1'b0);
      add_cp(55, 0, 8, 0);
      add_window(60, 8, 3'd0, 8'b0010_0100, 1'b0);
      add_cp(90, 0, 8, err2);
      // only antenna 1 enabled: ant 0 and ant 5 windows must be ignored
      set_mask(95, 4'b0010);
      add_window(100, 8, 3'd0, 8'h00, 1'b0);
      add_window(130, 8, 3'd1, 8'h00, 1'b0);
      add_window(160, 8, 3'd5, 8'h00, 1'b0);
      add_cp(200, 1, 8, 0);
      // continuous valid with an antenna change after 4 samples
      set_mask(200, 4'b0011);
      for (int i = 0; i < 4; i++) put_sample(220 + i, 3'd0, 7'(i), 1'b0);
      for (int i = 0; i < 8; i++) put_sample(224 + i, 3'd1, 7'(i), 1'b0);
      add_cp(236, 0, 4, 0);
      // global enable dropped mid-window
      set_mask(300, 4'b0001);
      add_window(300, 10, 3'd0, 8'h00, 1'b0);
      for (int i = 316; i < 322; i++) s_en[i] = 0;
      add_cp(330, 1, -1, -1);
      // reset in the middle of a window, then a clean window
      add_window(360, 8, 3'd0, 8'h00, 1'b0);
      s_rst[375] = 1;
      s_rst[376] = 1;
      add_window(400, 8, 3'd0, 8'h00, 1'b0);
      add_cp(430, 0, 8, 0);
      // long fully-mismatched window
      add_window(440, 200, 3'd0, 8'h00, 1'b1);
      add_cp(670, 0, 127, err200);
      // randomized windows
      t = 700;
      while (t < 1090) begin
         set_mask(t, 4'($urandom));
         t += $urandom_range(1, 8);
         len = $urandom_range(1, 24);
         ant = 3'($urandom);
         for (int i = 0; i < len && t < 1100; i++) begin
            if ($urandom_range(0, 9) == 0) ant = 3'($urandom);
            put_sample(t, ant, 7'($urandom), $urandom_range(0, 4) == 0);
            t++;
         end
      end
      for (int i = 700; i < 1100; i++) if ($urandom_range(0, 39) == 0) s_en[i] = 0;

      run_model();

      bus.amp_seq0 = amp[0]; bus.amp_seq1 = amp[1]; bus.amp_seq2 = amp[2]; bus.amp_seq3 = amp[3];
      bus.amp_seq4 = amp[4]; bus.amp_seq5 = amp[5]; bus.amp_seq6 = amp[6]; bus.amp_seq7 = amp[7];

      for (int c = 0; c < N; c++) begin
         asy_rst              = s_rst[c];
         bus.rx_seq_valid     = s_v[c];
         bus.rx_ant_cnt       = s_ant[c];
         bus.i_seq_cnt        = s_seq[c];
         bus.ul_rdata         = s_data[c];
         bus.i_seq_extract_en = s_en[c];
         bus.reg_cal_ant_en   = s_mask[c];
         if (s_rst[c] && (c == 0 || !s_rst[c > 0 ? c - 1 : 0])) begin
            #1;
            check_reset_zero(c);
         end
         @(posedge clk);
         @(negedge clk);
         check_val("cap_wr",  c, 32'(bus.o_cap_wr),  32'(e_wr[c]));
         check_val("done",    c, 32'(bus.o_done),    32'(e_done[c]));
         check_val("abort",   c, 32'(bus.o_abort),   32'(e_abort[c]));
         check_val("ant_idx", c, 32'(bus.o_ant_idx), 32'(e_ant[c]));
         check_val("smp_cnt", c, 32'(bus.o_smp_cnt), 32'(e_smp[c]));
         check_val("err_cnt", c, 32'(bus.o_err_cnt), 32'(e_err[c]));
         if (e_wr[c]) begin
            check_val("cap_addr", c, 32'(bus.o_cap_addr), 32'(e_addr[c]));
            check_val("cap_data", c, bus.o_cap_data, e_data[c]);
         end
         if (c == 30) check_val("first_wr_early", c, 32'(bus.o_cap_wr), 32'd0);
         if (c == 31) begin
            check_val("first_wr",      c, 32'(bus.o_cap_wr),   32'd1);
            check_val("first_wr_addr", c, 32'(bus.o_cap_addr), 32'd0);
         end
         for (int i = 0; i < cp_t.size(); i++) begin
            if (cp_t[i] == c) begin
               if (cp_ant[i] >= 0) check_val("cp_ant", c, 32'(bus.o_ant_idx), 32'(cp_ant[i]));
               if (cp_smp[i] >= 0) check_val("cp_smp", c, 32'(bus.o_smp_cnt), 32'(cp_smp[i]));
               if (cp_err[i] >= 0) check_val("cp_err", c, 32'(bus.o_err_cnt), 32'(cp_err[i]));
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
